// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port memory with a
// bidirectional data bus. Each access takes one ACCESS cycle and one RESP cycle.
module memory_arbiter #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              a_done,
    output logic              b_done,
    output logic [DWIDTH-1:0] a_rdata,
    output logic [DWIDTH-1:0] b_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [DWIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DWIDTH-1:0] b_rdata_q, b_rdata_d;
    logic              any_req;
    logic              win_b;

    always_comb begin
        any_req = a_req | b_req;
        // On a tie the requester that was not served last wins.
        win_b   = b_req & (~a_req | (last_q == SEL_A));
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            owner_q   <= SEL_A;
            last_q    <= SEL_B;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        owner_d   = owner_q;
        last_d    = last_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            // RESP arbitrates exactly like IDLE so back-to-back accesses
            // run at one per two cycles.
            IDLE, RESP: begin
                if (any_req) begin
                    state_d = ACCESS;
                    owner_d = win_b;
                    last_d  = win_b;
                    we_d    = win_b ? b_we    : a_we;
                    addr_d  = win_b ? b_addr  : a_addr;
                    wdata_d = win_b ? b_wdata : a_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    if (owner_q == SEL_B) begin
                        b_rdata_d = mem_data;
                    end else begin
                        a_rdata_d = mem_data;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_wr   = (state_q == ACCESS) &  we_q;
    assign mem_rd   = (state_q == ACCESS) & ~we_q;
    assign mem_addr = addr_q;
    assign mem_data = mem_wr ? wdata_q : {DWIDTH{1'bz}};

    assign a_done   = (state_q == RESP) & (owner_q == SEL_A);
    assign b_done   = (state_q == RESP) & (owner_q == SEL_B);
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a small memory device on the shared bus, a
// transaction-level reference model, a per-cycle compare and directed scenarios.
module tb_memory_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic          a_we = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_done, b_done, mem_wr, mem_rd;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    tri   [DW-1:0] mem_data;

    always #5 clk = ~clk;

    memory_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_(rst_),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_done(a_done), .b_done(b_done), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // Memory device: drives the bus only while read-enabled; the bus floats high otherwise.
    logic [DW-1:0] dev_mem [0:(1<<AW)-1];
    assign mem_data = mem_rd ? dev_mem[mem_addr] : {DW{1'bz}};
    always @(posedge clk) if (mem_wr) dev_mem[mem_addr] <= mem_data;
    for (genvar gi = 0; gi < DW; gi++) begin : g_pu
        pullup (mem_data[gi]);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an access granted at one edge occupies the next cycle,
    // completes at the following edge, and no grant can happen while it runs.
    typedef struct packed {
        logic          v;
        logic          who;   // 0 = A, 1 = B
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    acc_t          cur_m  = '0;
    acc_t          resp_m = '0;
    logic          last_m = 1'b1;
    logic          who_m;
    logic          busy_m;
    logic [DW-1:0] exp_ard = '0, exp_brd = '0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    initial begin
        forever begin
            @(posedge clk or negedge rst_);
            if (!rst_) begin
                cur_m = '0; resp_m = '0; last_m = 1'b1; exp_ard = '0; exp_brd = '0;
            end else begin
                busy_m = cur_m.v;
                resp_m = cur_m;
                if (cur_m.v) begin
                    if (cur_m.we) ref_mem[cur_m.addr] = cur_m.wdata;
                    else if (cur_m.who) exp_brd = ref_mem[cur_m.addr];
                    else exp_ard = ref_mem[cur_m.addr];
                end
                cur_m = '0;
                if (!busy_m && (a_req || b_req)) begin
                    who_m  = (a_req && b_req) ? !last_m : b_req;
                    last_m = who_m;
                    cur_m  = who_m ? {1'b1, 1'b1, b_we, b_addr, b_wdata}
                                   : {1'b1, 1'b0, a_we, a_addr, a_wdata};
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("mem_wr", 32'(mem_wr), 32'(cur_m.v && cur_m.we));
            chk("mem_rd", 32'(mem_rd), 32'(cur_m.v && !cur_m.we));
            if (cur_m.v) chk("mem_addr", 32'(mem_addr), 32'(cur_m.addr));
            if (cur_m.v && cur_m.we) chk("mem_data_wr", 32'(mem_data), 32'(cur_m.wdata));
            if (!cur_m.v) chk("mem_data_hiz", 32'(mem_data), 32'hFF);
            chk("a_done", 32'(a_done), 32'(resp_m.v && !resp_m.who));
            chk("b_done", 32'(b_done), 32'(resp_m.v && resp_m.who));
            chk("a_rdata", 32'(a_rdata), 32'(exp_ard));
            chk("b_rdata", 32'(b_rdata), 32'(exp_brd));
        end
    end

    // Done monitor: one line per completed transaction.
    int cyc = 0, a_done_cnt = 0, b_done_cnt = 0, both_cnt = 0, wr_cycles = 0;
    bit done_who_q[$];
    int done_cyc_q[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_wr) wr_cycles++;
            if (a_done && b_done) both_cnt++;
            if (a_done) begin
                a_done_cnt++; done_who_q.push_back(1'b0); done_cyc_q.push_back(cyc);
                $display("txn done A rdata=%h cycle=%0d", a_rdata, cyc);
            end
            if (b_done) begin
                b_done_cnt++; done_who_q.push_back(1'b1); done_cyc_q.push_back(cyc);
                $display("txn done B rdata=%h cycle=%0d", b_rdata, cyc);
            end
        end
    end

    function automatic logic [DW-1:0] a_val(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    function automatic logic [DW-1:0] b_val(input int i);
        return 8'(i) ^ 8'hC3;
    endfunction

    // One request, held only for the arbitration edge; inputs are then
    // scrambled during ACCESS. lat counts negedges from request to done.
    task automatic do_access(input bit who, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, output int lat);
        @(negedge clk);
        if (!who) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
        else      begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
        @(negedge clk);
        a_req = 0; b_req = 0;
        if (!who) begin a_we = !we; a_addr = ~addr; a_wdata = ~wdata; end
        else      begin b_we = !we; b_addr = ~addr; b_wdata = ~wdata; end
        lat = 1;
        while (lat < 8 && !(who ? b_done : a_done)) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_data_hiz", 32'(mem_data), 32'hFF);
        chk("rst_a_done", 32'(a_done), 0);
        chk("rst_b_done", 32'(b_done), 0);
        chk("rst_a_rdata", 32'(a_rdata), 0);
        chk("rst_b_rdata", 32'(b_rdata), 0);
        @(negedge clk);
        rst_ = 1;

        // Single write then read-back on the top address.
        wr_cycles = 0;
        do_access(0, 1, 5'h1F, 8'hA5, lat);
        chk("wr_latency", 32'(lat), 2);
        repeat (2) @(negedge clk);
        chk("wr_strobe_cycles", 32'(wr_cycles), 1);
        do_access(0, 0, 5'h1F, 8'h00, lat);
        chk("rd_latency", 32'(lat), 2);
        chk("rd_a5", 32'(a_rdata), 32'hA5);

        // Fill every address from both sides, descending, then read all back.
        for (int i = 31; i >= 0; i--) begin
            do_access(0, 1, 5'(i), a_val(i), lat);
            do_access(1, 1, 5'(i), b_val(i), lat);
        end
        for (int i = 31; i >= 0; i--) begin
            do_access(i[0], 0, 5'(i), 8'h00, lat);
            chk("sweep_latency", 32'(lat), 2);
            chk("sweep_rdata", 32'(i[0] ? b_rdata : a_rdata), 32'(b_val(i)));
        end

        // Inputs scrambled during ACCESS must not reach the memory.
        do_access(0, 1, 5'd3, 8'h3C, lat);
        do_access(1, 0, 5'd3, 8'h00, lat);
        chk("latched_addr3", 32'(b_rdata), 32'h3C);
        do_access(1, 0, 5'd28, 8'h00, lat);
        chk("untouched_addr28", 32'(b_rdata), 32'(b_val(28)));

        // A one-cycle B pulse while A is in ACCESS is never granted.
        a_done_cnt = 0; b_done_cnt = 0;
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 5'd5;
        @(negedge clk);
        a_req = 0; b_req = 1; b_we = 1; b_addr = 5'd6; b_wdata = 8'h00;
        @(negedge clk);
        b_req = 0;
        repeat (4) @(negedge clk);
        chk("pulse_a_served", 32'(a_done_cnt), 1);
        chk("pulse_b_ignored", 32'(b_done_cnt), 0);
        do_access(0, 0, 5'd6, 8'h00, lat);
        chk("pulse_no_write", 32'(a_rdata), 32'(b_val(6)));

        // Sustained tie after reset: A, B, A, B, one done every two cycles.
        @(negedge clk); #2; rst_ = 0;
        repeat (2) @(negedge clk);
        rst_ = 1;
        done_who_q.delete(); done_cyc_q.delete(); both_cnt = 0;
        @(negedge clk);
        a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 5'd1; b_addr = 5'd2;
        repeat (8) @(negedge clk);
        a_req = 0; b_req = 0;
        repeat (4) @(negedge clk);
        chk("tie_done_count", 32'(done_who_q.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < done_who_q.size()) chk("tie_order", 32'(done_who_q[i]), 32'(i % 2));
        for (int i = 1; i < 4; i++)
            if (i < done_cyc_q.size()) chk("tie_spacing", 32'(done_cyc_q[i] - done_cyc_q[i-1]), 2);
        chk("never_both_done", 32'(both_cnt), 0);
        chk("tie_a_rdata", 32'(a_rdata), 32'(b_val(1)));
        chk("tie_b_rdata", 32'(b_rdata), 32'(b_val(2)));

        // Reset in the middle of a write ACCESS aborts it.
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 5'd7; a_wdata = 8'h99;
        @(negedge clk);
        a_req = 0;
        chk("pre_rst_mem_wr", 32'(mem_wr), 1);
        #2; rst_ = 0; #1;
        chk("async_mem_wr", 32'(mem_wr), 0);
        chk("async_mem_addr", 32'(mem_addr), 0);
        chk("async_mem_data_hiz", 32'(mem_data), 32'hFF);
        a_done_cnt = 0; b_done_cnt = 0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(a_done_cnt + b_done_cnt), 0);
        rst_ = 1; a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 5'd7; b_addr = 5'd8;
        @(negedge clk);
        a_req = 0; b_req = 0;
        @(negedge clk);
        chk("post_rst_a_first", 32'(a_done), 1);
        chk("post_rst_b_idle", 32'(b_done), 0);
        chk("aborted_write_absent", 32'(a_rdata), 32'(b_val(7)));
        repeat (3) @(negedge clk);
        chk("post_rst_b_never", 32'(b_done_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
